// File: rtl/ptp_pkg.sv
// Shared widths, field positions and constants for the PTP hardware clock.
package ptp_pkg;

  localparam int DEF_FNS_W = 16;
  localparam int TOD_S_W   = 48;
  localparam int TOD_NS_W  = 30;
  localparam int REL_NS_W  = 48;
  localparam int ADJ_W     = 16;

  // ns part of an intermediate sum: holds -2^15 .. 1e9 + 2^15 + inc
  localparam int SUM_NS_W = 31;
  localparam logic [SUM_NS_W-1:0] NS_PER_S = 31'd1_000_000_000;

  typedef enum logic [1:0] {
    ROLL_NONE,
    ROLL_CARRY,
    ROLL_BORROW
  } roll_t;

endpackage

// File: rtl/ptp_clock_gen_if.sv
// Load/adjust inputs and timestamp outputs of the PTP clock generator.
interface ptp_clock_gen_if import ptp_pkg::*; #(
  parameter int PERIOD_NS_W = 4,
  parameter int FNS_W       = DEF_FNS_W
) ();

  logic [TOD_S_W-1:0]            input_ts_tod_s;
  logic [TOD_NS_W-1:0]           input_ts_tod_ns;
  logic                          input_ts_tod_valid;
  logic [REL_NS_W-1:0]           input_ts_rel;
  logic                          input_ts_rel_valid;
  logic [PERIOD_NS_W-1:0]        input_period_ns;
  logic [FNS_W-1:0]              input_period_fns;
  logic                          input_period_valid;
  logic [ADJ_W-1:0]              input_adj_ns;
  logic [15:0]                   input_adj_count;
  logic                          input_adj_valid;
  logic                          output_adj_active;
  logic [TOD_S_W+32+FNS_W-1:0]   output_ts_tod;
  logic [REL_NS_W+FNS_W-1:0]     output_ts_rel;
  logic                          output_ts_step;
  logic                          output_pps;
  logic                          output_pps_str;

  modport master (
    output input_ts_tod_s, input_ts_tod_ns, input_ts_tod_valid,
    output input_ts_rel, input_ts_rel_valid,
    output input_period_ns, input_period_fns, input_period_valid,
    output input_adj_ns, input_adj_count, input_adj_valid,
    input  output_adj_active, output_ts_tod, output_ts_rel,
    input  output_ts_step, output_pps, output_pps_str
  );

  modport slave (
    input  input_ts_tod_s, input_ts_tod_ns, input_ts_tod_valid,
    input  input_ts_rel, input_ts_rel_valid,
    input  input_period_ns, input_period_fns, input_period_valid,
    input  input_adj_ns, input_adj_count, input_adj_valid,
    output output_adj_active, output_ts_tod, output_ts_rel,
    output output_ts_step, output_pps, output_pps_str
  );

endinterface

// File: rtl/ptp_tod_adder.sv
// ToD ns/fns adder with signed slew; the +1e9 and -1e9 corrected sums are
// formed in parallel and the in-range one is selected.
module ptp_tod_adder import ptp_pkg::*; #(
  parameter int FNS_W = DEF_FNS_W,
  parameter int INC_W = 21
) (
  input  logic [TOD_NS_W-1:0] ns_in,
  input  logic [FNS_W-1:0]    fns_in,
  input  logic [INC_W-1:0]    inc,
  input  logic [ADJ_W-1:0]    slew,
  output logic [TOD_NS_W-1:0] ns_out,
  output logic [FNS_W-1:0]    fns_out,
  output logic                carry,
  output logic                borrow
);

  localparam int SW = SUM_NS_W + FNS_W;
  localparam int LW = TOD_NS_W + FNS_W;
  localparam logic [SW-1:0] ONE_S = {NS_PER_S, {FNS_W{1'b0}}};

  logic [SW-1:0] base;
  logic [SW-1:0] slew_ext;
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_sub;
  logic [LW-1:0] sum_add;
  roll_t         roll;

  assign base     = {{(SW-LW){1'b0}}, ns_in, fns_in};
  assign slew_ext = {{(SUM_NS_W-ADJ_W){slew[ADJ_W-1]}}, slew, {FNS_W{1'b0}}};
  assign sum      = base + {{(SW-INC_W){1'b0}}, inc} + slew_ext;
  assign sum_sub  = sum - ONE_S;
  // a negative sum is at most a slew below zero, so the low bits suffice
  assign sum_add  = sum[LW-1:0] + ONE_S[LW-1:0];

  always_comb begin
    roll = ROLL_NONE;
    if (!sum_sub[SW-1]) begin
      roll = ROLL_CARRY;
    end else if (sum[SW-1]) begin
      roll = ROLL_BORROW;
    end
  end

  always_comb begin
    {ns_out, fns_out} = sum[LW-1:0];
    case (roll)
      ROLL_CARRY:  {ns_out, fns_out} = sum_sub[LW-1:0];
      ROLL_BORROW: {ns_out, fns_out} = sum_add;
      default: ;
    endcase
  end

  assign carry  = (roll == ROLL_CARRY);
  assign borrow = (roll == ROLL_BORROW);

endmodule

// File: rtl/ptp_clock_gen.sv
// PTP hardware clock: 96-bit ToD and 64-bit relative time with runtime period,
// bounded offset slew, fixed-cadence drift trim and a stretched PPS.
module ptp_clock_gen import ptp_pkg::*; #(
  parameter int                     PERIOD_NS_W    = 4,
  parameter int                     FNS_W          = DEF_FNS_W,
  parameter logic [PERIOD_NS_W-1:0] PERIOD_NS      = 4'h6,
  parameter logic [FNS_W-1:0]       PERIOD_FNS     = 16'h6666,
  parameter bit                     DRIFT_ENABLE   = 1'b1,
  parameter logic [FNS_W-1:0]       DRIFT_FNS      = 16'h0002,
  parameter logic [15:0]            DRIFT_RATE     = 16'd5,
  parameter logic [15:0]            PPS_STR_CYCLES = 16'd100
) (
  input  logic           clk,
  input  logic           rst,
  ptp_clock_gen_if.slave bus
);

  localparam int INC_W = PERIOD_NS_W + FNS_W + 1;
  localparam int REL_W = REL_NS_W + FNS_W;

  logic [TOD_S_W-1:0]     tod_s;
  logic [TOD_NS_W-1:0]    tod_ns;
  logic [FNS_W-1:0]       tod_fns;
  logic [REL_W-1:0]       rel;
  logic [PERIOD_NS_W-1:0] period_ns;
  logic [FNS_W-1:0]       period_fns;
  logic [15:0]            drift_cnt;
  logic [15:0]            adj_cnt;
  logic [ADJ_W-1:0]       adj_val;
  logic [15:0]            str_cnt;
  logic                   ts_step;
  logic                   pps;

  logic                   drift_tick;
  logic                   adj_active;
  logic [INC_W-1:0]       inc;
  logic [ADJ_W-1:0]       slew;
  logic [TOD_NS_W-1:0]    sum_ns;
  logic [FNS_W-1:0]       sum_fns;
  logic                   carry;
  logic                   borrow;
  logic                   pps_fire;

  assign drift_tick = DRIFT_ENABLE && (drift_cnt == DRIFT_RATE - 16'd1);
  assign inc = {1'b0, period_ns, period_fns}
             + (drift_tick ? {{(INC_W-FNS_W){1'b0}}, DRIFT_FNS} : {INC_W{1'b0}});
  assign adj_active = (adj_cnt != 16'd0);
  assign slew       = adj_active ? adj_val : {ADJ_W{1'b0}};
  // a ToD load suppresses the rollover, so no PPS on the load cycle
  assign pps_fire   = carry && !bus.input_ts_tod_valid;

  ptp_tod_adder #(
    .FNS_W (FNS_W),
    .INC_W (INC_W)
  ) u_adder (
    .ns_in   (tod_ns),
    .fns_in  (tod_fns),
    .inc     (inc),
    .slew    (slew),
    .ns_out  (sum_ns),
    .fns_out (sum_fns),
    .carry   (carry),
    .borrow  (borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tod_s      <= '0;
      tod_ns     <= '0;
      tod_fns    <= '0;
      rel        <= '0;
      period_ns  <= PERIOD_NS;
      period_fns <= PERIOD_FNS;
      drift_cnt  <= '0;
      adj_cnt    <= '0;
      adj_val    <= '0;
      str_cnt    <= '0;
      ts_step    <= 1'b0;
      pps        <= 1'b0;
    end else begin
      if (bus.input_period_valid) begin
        period_ns  <= bus.input_period_ns;
        period_fns <= bus.input_period_fns;
      end

      if (drift_tick || !DRIFT_ENABLE) begin
        drift_cnt <= '0;
      end else begin
        drift_cnt <= drift_cnt + 16'd1;
      end

      if (bus.input_adj_valid) begin
        adj_cnt <= bus.input_adj_count;
        adj_val <= bus.input_adj_ns;
      end else if (adj_active) begin
        adj_cnt <= adj_cnt - 16'd1;
      end

      if (bus.input_ts_tod_valid) begin
        tod_s   <= bus.input_ts_tod_s;
        tod_ns  <= bus.input_ts_tod_ns;
        tod_fns <= '0;
      end else begin
        tod_ns  <= sum_ns;
        tod_fns <= sum_fns;
        if (carry) begin
          tod_s <= tod_s + 48'd1;
        end else if (borrow) begin
          tod_s <= tod_s - 48'd1;
        end
      end

      if (bus.input_ts_rel_valid) begin
        rel <= {bus.input_ts_rel, {FNS_W{1'b0}}};
      end else begin
        rel <= rel + {{(REL_W-INC_W){1'b0}}, inc};
      end

      ts_step <= bus.input_ts_tod_valid || bus.input_ts_rel_valid;
      pps     <= pps_fire;

      if (pps_fire) begin
        str_cnt <= PPS_STR_CYCLES;
      end else if (str_cnt != 16'd0) begin
        str_cnt <= str_cnt - 16'd1;
      end
    end
  end

  assign bus.output_ts_tod     = {tod_s, 2'b00, tod_ns, tod_fns};
  assign bus.output_ts_rel     = rel;
  assign bus.output_ts_step    = ts_step;
  assign bus.output_pps        = pps;
  assign bus.output_pps_str    = (str_cnt != 16'd0);
  assign bus.output_adj_active = adj_active;

endmodule
